// File: rtl/coin_pkg.sv
// Shared types and default parameters for the coin acceptor front end.
//   chan_state_t : per-channel sensor FSM state
//   *_DEF        : default values for DEBOUNCE_CYCLES, JAM_CYCLES and CNT_W
package coin_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'b00,
    HIGH = 2'b01,
    JAM  = 2'b10
  } chan_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int JAM_CYCLES_DEF      = 1024;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: 2-flop synchroniser, debounce counter, sensor FSM
// and jam timer.
//   clk, reset : system clock, async active-high reset
//   raw        : raw bouncy sensor, asynchronous to clk
//   rise_evt   : single-cycle event on a debounced LOW->HIGH transition
//   in_jam     : 1 while the channel FSM is in JAM
//
// state | meaning
// ------+---------------------------------------------------------------
// LOW   | debounced sensor low, waiting for a coin
// HIGH  | coin seen and reported once; jam timer running
// JAM   | sensor stuck high too long; silent until a debounced fall
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise_evt,
  output logic in_jam
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int JAM_W = $clog2(JAM_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  // The level is already one cycle high when HIGH is entered, and the
  // terminal-count cycle adds one more; loading N-2 makes the level high
  // for exactly JAM_CYCLES cycles before JAM is entered.
  localparam logic [JAM_W-1:0] JAM_LOAD = JAM_W'(JAM_CYCLES - 2);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [JAM_W-1:0]  jam_tmr_q, jam_tmr_d;
  chan_state_t       state_q, state_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;

    // Counter only survives while the sample disagrees with the level;
    // the DEBOUNCE_CYCLES-th consecutive disagreement flips the level.
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    state_d   = state_q;
    jam_tmr_d = jam_tmr_q;
    rise_evt  = 1'b0;
    case (state_q)
      LOW: begin
        if (level_q) begin
          state_d   = HIGH;
          rise_evt  = 1'b1;
          jam_tmr_d = JAM_LOAD;
        end
      end
      HIGH: begin
        if (!level_q) begin
          state_d = LOW;
        end else if (jam_tmr_q == '0) begin
          state_d = JAM;
        end else begin
          jam_tmr_d = jam_tmr_q - JAM_W'(1);
        end
      end
      JAM: begin
        if (!level_q) begin
          state_d = LOW;
        end
      end
      default: state_d = LOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      jam_tmr_q <= '0;
      state_q   <= LOW;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      jam_tmr_q <= jam_tmr_d;
      state_q   <= state_d;
    end
  end

  assign in_jam = (state_q == JAM);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced sensor channels feeding event
// arbitration, registered credit/reject pulses and saturating tallies.
//   clk, reset             : system clock, async active-high reset
//   raw_coin_1, raw_coin_2 : raw slot sensors (async, bouncy)
//   accept_en              : 1 = credit coins, 0 = divert to return chute
//   coin_1, coin_2         : one-cycle credit pulses
//   reject                 : one-cycle pulse, coin diverted
//   jam                    : level, either channel jammed
//   count_1, count_2       : saturating accepted-coin tallies
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_coin_1,
  input  logic             raw_coin_2,
  input  logic             accept_en,
  output logic             coin_1,
  output logic             coin_2,
  output logic             reject,
  output logic             jam,
  output logic [CNT_W-1:0] count_1,
  output logic [CNT_W-1:0] count_2
);

  logic rise_1, rise_2;
  logic in_jam_1, in_jam_2;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_chan_1 (
    .clk      (clk),
    .reset    (reset),
    .raw      (raw_coin_1),
    .rise_evt (rise_1),
    .in_jam   (in_jam_1)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_chan_2 (
    .clk      (clk),
    .reset    (reset),
    .raw      (raw_coin_2),
    .rise_evt (rise_2),
    .in_jam   (in_jam_2)
  );

  logic             coin_1_q, coin_1_d;
  logic             coin_2_q, coin_2_d;
  logic             reject_q, reject_d;
  logic             jam_q, jam_d;
  logic [CNT_W-1:0] count_1_q, count_1_d;
  logic [CNT_W-1:0] count_2_q, count_2_d;

  always_comb begin
    coin_1_d  = 1'b0;
    coin_2_d  = 1'b0;
    reject_d  = 1'b0;
    count_1_d = count_1_q;
    count_2_d = count_2_q;
    jam_d     = in_jam_1 | in_jam_2;

    // Simultaneous inserts cannot be told apart, so both are refused.
    case ({rise_2, rise_1})
      2'b11: reject_d = 1'b1;
      2'b01: begin
        if (accept_en && !jam_q) begin
          coin_1_d = 1'b1;
          if (count_1_q != '1) count_1_d = count_1_q + CNT_W'(1);
        end else begin
          reject_d = 1'b1;
        end
      end
      2'b10: begin
        if (accept_en && !jam_q) begin
          coin_2_d = 1'b1;
          if (count_2_q != '1) count_2_d = count_2_q + CNT_W'(1);
        end else begin
          reject_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin_1_q  <= 1'b0;
      coin_2_q  <= 1'b0;
      reject_q  <= 1'b0;
      jam_q     <= 1'b0;
      count_1_q <= '0;
      count_2_q <= '0;
    end else begin
      coin_1_q  <= coin_1_d;
      coin_2_q  <= coin_2_d;
      reject_q  <= reject_d;
      jam_q     <= jam_d;
      count_1_q <= count_1_d;
      count_2_q <= count_2_d;
    end
  end

  assign coin_1  = coin_1_q;
  assign coin_2  = coin_2_q;
  assign reject  = reject_q;
  assign jam     = jam_q;
  assign count_1 = count_1_q;
  assign count_2 = count_2_q;

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

  localparam int DEB = 16;
  localparam int JAMC = 1024;
  localparam int CW = 8;
  localparam int LAT = DEB + 3;  // negedge of drive -> negedge inside pulse cycle

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          raw_coin_1 = 1'b0;
  logic          raw_coin_2 = 1'b0;
  logic          accept_en = 1'b1;
  logic          coin_1, coin_2, reject, jam;
  logic [CW-1:0] count_1, count_2;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DEB),
    .JAM_CYCLES      (JAMC),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_coin_1 (raw_coin_1),
    .raw_coin_2 (raw_coin_2),
    .accept_en  (accept_en),
    .coin_1     (coin_1),
    .coin_2     (coin_2),
    .reject     (reject),
    .jam        (jam),
    .count_1    (count_1),
    .count_2    (count_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected output pulses.
  typedef struct {
    int unsigned cyc;
    bit c1;
    bit c2;
    bit rj;
  } exp_t;
  exp_t sb[$];

  int  m_cnt1 = 0;
  int  m_cnt2 = 0;
  bit  exp_jam = 1'b0;

  task automatic push_exp(input bit r1, input bit r2, input bit en);
    exp_t e;
    e.cyc = cyc + LAT;
    e.c1 = 1'b0; e.c2 = 1'b0; e.rj = 1'b0;
    if (r1 && r2) e.rj = 1'b1;
    else if (en && !exp_jam) begin
      if (r1) begin e.c1 = 1'b1; if (m_cnt1 < 255) m_cnt1++; end
      else    begin e.c2 = 1'b1; if (m_cnt2 < 255) m_cnt2++; end
    end else e.rj = 1'b1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && (coin_1 || coin_2 || reject)) begin
      chk("coin_exclusive", coin_1 & coin_2, 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {coin_1, coin_2, reject}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_bits", {coin_1, coin_2, reject}, {e.c1, e.c2, e.rj});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert(input bit r1, input bit r2, input bit en,
                        input int hold, input int gap);
    accept_en = en;
    if (r1) raw_coin_1 = 1'b1;
    if (r2) raw_coin_2 = 1'b1;
    push_exp(r1, r2, en);
    wait_cyc(hold);
    if (r1) raw_coin_1 = 1'b0;
    if (r2) raw_coin_2 = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_count_1"}, count_1, m_cnt1);
    chk({tag, "_count_2"}, count_2, m_cnt2);
  endtask

  typedef struct {
    bit r1;
    bit r2;
    bit en;
    int exp_c1;
    int exp_c2;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n0;
    int rel;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2, 1};

    wait_cyc(3);
    chk("rst_outputs", {coin_1, coin_2, reject, jam}, 0);
    reset = 1'b0;
    wait_cyc(3);
    chk("rst_count_1", count_1, 0);
    chk("rst_count_2", count_2, 0);
    chk("rst_jam", jam, 0);

    for (int i = 0; i < 6; i++) begin
      insert(vecs[i].r1, vecs[i].r2, vecs[i].en, 40, 30);
      chk("vec_count_1", count_1, vecs[i].exp_c1);
      chk("vec_count_2", count_2, vecs[i].exp_c2);
    end

    // Bouncy coin 2: four 5-cycle glitches, then stable insert.
    for (int i = 0; i < 4; i++) begin
      raw_coin_2 = 1'b1; wait_cyc(5);
      raw_coin_2 = 1'b0; wait_cyc(5);
    end
    insert(1'b0, 1'b1, 1'b1, 40, 30);
    chk_counts("bounce");

    // accept_en matters only in the event cycle.
    accept_en = 1'b0; raw_coin_1 = 1'b1; push_exp(1'b1, 1'b0, 1'b1);
    wait_cyc(10); accept_en = 1'b1;
    wait_cyc(15); accept_en = 1'b0;
    wait_cyc(15); raw_coin_1 = 1'b0; wait_cyc(30);
    accept_en = 1'b1; raw_coin_2 = 1'b1; push_exp(1'b0, 1'b1, 1'b0);
    wait_cyc(10); accept_en = 1'b0;
    wait_cyc(15); accept_en = 1'b1;
    wait_cyc(15); raw_coin_2 = 1'b0; wait_cyc(30);
    chk_counts("toggle_en");

    // Jam: raw_coin_1 held 2000 cycles.
    accept_en = 1'b1;
    raw_coin_1 = 1'b1; n0 = cyc + 1; push_exp(1'b1, 1'b0, 1'b1);
    while (cyc < n0 + 1030) @(negedge clk);
    chk("jam_before", jam, 0);
    while (cyc < n0 + 1060) @(negedge clk);
    chk("jam_after", jam, 1);
    exp_jam = 1'b1;
    insert(1'b0, 1'b1, 1'b1, 40, 30);
    chk_counts("jam_insert");
    while (cyc < n0 + 1999) @(negedge clk);
    chk("jam_held", jam, 1);
    raw_coin_1 = 1'b0; rel = cyc;
    wait_cyc(5);
    chk("jam_release_early", jam, 1);
    wait_cyc(25);
    chk("jam_release", jam, 0);
    exp_jam = 1'b0;
    wait_cyc(20);
    chk_counts("jam_exit");

    // Saturate count_1.
    while (m_cnt1 < 255) insert(1'b1, 1'b0, 1'b1, 25, 25);
    chk("sat_count_1", count_1, 255);
    insert(1'b1, 1'b0, 1'b1, 25, 25);
    chk("sat_hold_count_1", count_1, 255);

    // Async reset mid-debounce, sensor still high after release.
    raw_coin_1 = 1'b1;
    wait_cyc(10);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outputs", {coin_1, coin_2, reject, jam}, 0);
    chk("midrst_count_1", count_1, 0);
    chk("midrst_count_2", count_2, 0);
    sb.delete();
    m_cnt1 = 0; m_cnt2 = 0;
    wait_cyc(3);
    reset = 1'b0;
    push_exp(1'b1, 1'b0, 1'b1);
    wait_cyc(40);
    raw_coin_1 = 1'b0;
    wait_cyc(30);
    chk_counts("post_rst");

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
